// File: rtl/br_predictor_bht.sv
// Table-based branch predictor for the IF stage: per-PC saturating counters,
// a tagged in-flight record pipeline, and EX-stage mispredict flush/redirect.

module bht_ctr #(
  parameter int CTR_W    = 2,
  parameter int CTR_INIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd,
  input  logic             taken,
  output logic [CTR_W-1:0] ctr
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ctr <= CTR_W'(CTR_INIT);
    else if (upd) begin
      if (taken && ctr != '1)
        ctr <= ctr + CTR_W'(1);
      else if (!taken && ctr != '0)
        ctr <= ctr - CTR_W'(1);
    end
  end
endmodule

module br_predictor_bht #(
  parameter int ADDR_W     = 32,
  parameter int IDX_W      = 4,
  parameter int CTR_W      = 2,
  parameter int CTR_INIT   = 1,
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_en,
  input  logic              if_br,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  input  logic              is_br_ex,
  input  logic              branch_ex,
  input  logic [ADDR_W-1:0] ex_target,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  mispred_cnt
);
  localparam int ENTRIES = 1 << IDX_W;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic              pred;
    logic [ADDR_W-1:0] pc4;
  } rec_t;

  logic [ENTRIES-1:0][CTR_W-1:0] ctr_q;
  logic [ENTRIES-1:0]            upd_vec;
  logic [IDX_W-1:0]              if_idx;
  rec_t                          if_rec;
  rec_t [PIPE_DEPTH-1:0]         rec_pipe;
  logic [PIPE_DEPTH-1:0]         vld_pipe;
  rec_t                          ex_rec;
  logic                          ex_vld;
  logic                          resolve;
  logic                          mis;
  logic [CNT_W-1:0]              cnt_q;

  assign if_idx     = if_pc[IDX_W+1:2];
  assign pred_taken = ctr_q[if_idx][CTR_W-1];
  assign if_rec     = '{idx: if_idx, pred: pred_taken, pc4: if_pc + ADDR_W'(4)};

  assign ex_rec  = rec_pipe[PIPE_DEPTH-1];
  assign ex_vld  = vld_pipe[PIPE_DEPTH-1];
  assign resolve = is_br_ex & ex_vld;
  assign mis     = resolve & (branch_ex != ex_rec.pred);

  assign flush       = mis;
  assign redirect_pc = mis ? (branch_ex ? ex_target : ex_rec.pc4) : '0;
  assign mispred_cnt = cnt_q;

  // One counter per table entry; lookups see the pre-update value this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_ctr
      assign upd_vec[gi] = pipe_en & resolve & (ex_rec.idx == IDX_W'(gi));
      bht_ctr #(.CTR_W(CTR_W), .CTR_INIT(CTR_INIT)) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .upd   (upd_vec[gi]),
        .taken (branch_ex),
        .ctr   (ctr_q[gi])
      );
    end
  endgenerate

  // A flush squashes everything younger than the retiring EX record,
  // including the record that would be allocated from IF this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      rec_pipe <= '0;
    end else if (pipe_en) begin
      vld_pipe[0] <= if_br & ~flush;
      rec_pipe[0] <= if_rec;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        vld_pipe[k] <= vld_pipe[k-1] & ~flush;
        rec_pipe[k] <= rec_pipe[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (mis && pipe_en && cnt_q != '1)
      cnt_q <= cnt_q + CNT_W'(1);
  end
endmodule

// File: tb/tb_br_predictor_bht.sv
// Directed bench for br_predictor_bht (PIPE_DEPTH=3, IDX_W=4, CNT_W=2).

module tb_br_predictor_bht;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pipe_en;
  logic              if_br;
  logic [ADDR_W-1:0] if_pc;
  logic              pred_taken;
  logic              is_br_ex;
  logic              branch_ex;
  logic [ADDR_W-1:0] ex_target;
  logic              flush;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  mispred_cnt;

  int n_cmp = 0;
  int n_err = 0;

  br_predictor_bht #(
    .ADDR_W(ADDR_W), .IDX_W(4), .CTR_W(2), .CTR_INIT(1),
    .PIPE_DEPTH(3), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .if_br(if_br), .if_pc(if_pc),
    .pred_taken(pred_taken), .is_br_ex(is_br_ex), .branch_ex(branch_ex),
    .ex_target(ex_target), .flush(flush), .redirect_pc(redirect_pc),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_en = 1'b1; if_br = 1'b0; if_pc = 32'h0;
    is_br_ex = 1'b0; branch_ex = 1'b0; ex_target = 32'h0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
  endtask

  // Fetch a branch at pc, then walk it to EX (three edges later).
  task automatic fetch_to_ex(input logic [ADDR_W-1:0] pc);
    if_br = 1'b1; if_pc = pc;
    tick();
    if_br = 1'b0; if_pc = 32'h0;
    tick(); tick();
  endtask

  // Full fetch + resolve of one branch, retiring on the next edge.
  task automatic run_branch(input logic [ADDR_W-1:0] pc, input logic taken);
    fetch_to_ex(pc);
    is_br_ex = 1'b1; branch_ex = taken; ex_target = 32'h100;
    tick();
    is_br_ex = 1'b0; branch_ex = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0; if_pc = 32'h40;
    #3;
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL rst_hold_flush got=%b exp=0", flush); end
    n_cmp++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL rst_hold_redirect got=%h exp=0", redirect_pc); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL rst_hold_pred got=%b exp=0", pred_taken); end
    tick();
    rst_n = 1'b1;
    tick();
    if_pc = 32'h40; #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL rst_pred_40 got=%b exp=0", pred_taken); end
    if_pc = 32'h7C; #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL rst_pred_7c got=%b exp=0", pred_taken); end
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL rst_flush got=%b exp=0", flush); end
    n_cmp++; if (mispred_cnt !== 2'd0) begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", mispred_cnt); end
  endtask

  task automatic test_mispredict_taken();
    apply_reset();
    fetch_to_ex(32'h40);
    is_br_ex = 1'b1; branch_ex = 1'b1; ex_target = 32'h100; #1;
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL mt_flush got=%b exp=1", flush); end
    n_cmp++; if (redirect_pc !== 32'h100) begin n_err++; $display("FAIL mt_redirect got=%h exp=100", redirect_pc); end
    tick();
    is_br_ex = 1'b0; branch_ex = 1'b0; if_pc = 32'h40; #1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL mt_pred_after got=%b exp=1", pred_taken); end
    n_cmp++; if (mispred_cnt !== 2'd1) begin n_err++; $display("FAIL mt_cnt got=%0d exp=1", mispred_cnt); end
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL mt_flush_clr got=%b exp=0", flush); end
  endtask

  task automatic test_train_saturate();
    apply_reset();
    run_branch(32'h40, 1'b1);  // 01->10 (mispredict)
    run_branch(32'h40, 1'b1);  // 10->11 (correct)
    if_pc = 32'h40; #1;
    n_cmp++; if (mispred_cnt !== 2'd1) begin n_err++; $display("FAIL tr_cnt_trained got=%0d exp=1", mispred_cnt); end
    fetch_to_ex(32'h40);
    is_br_ex = 1'b1; branch_ex = 1'b0; ex_target = 32'h100; #1;
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL tr_flush got=%b exp=1", flush); end
    n_cmp++; if (redirect_pc !== 32'h44) begin n_err++; $display("FAIL tr_redirect got=%h exp=44", redirect_pc); end
    tick();
    is_br_ex = 1'b0; if_pc = 32'h40; #1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL tr_pred_10 got=%b exp=1", pred_taken); end
    n_cmp++; if (mispred_cnt !== 2'd2) begin n_err++; $display("FAIL tr_cnt got=%0d exp=2", mispred_cnt); end
    // From 10 a second not-taken drops to 01; from 11 it would stay predicting taken.
    run_branch(32'h40, 1'b0);
    if_pc = 32'h40; #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL tr_pred_01 got=%b exp=0", pred_taken); end
  endtask

  task automatic test_back_to_back_squash();
    apply_reset();
    if_br = 1'b1; if_pc = 32'h40; tick();
    if_pc = 32'h44; tick();
    if_br = 1'b0; if_pc = 32'h0; tick();
    // 0x40 in EX; 0x48 offered from IF while flushing must not allocate.
    is_br_ex = 1'b1; branch_ex = 1'b1; ex_target = 32'h100;
    if_br = 1'b1; if_pc = 32'h48; #1;
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL bb_flush got=%b exp=1", flush); end
    tick();
    if_br = 1'b0; if_pc = 32'h0; #1;
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL bb_squash_44 got=%b exp=0", flush); end
    n_cmp++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL bb_redirect got=%h exp=0", redirect_pc); end
    tick(); tick(); #1;
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL bb_squash_48 got=%b exp=0", flush); end
    tick();
    is_br_ex = 1'b0; branch_ex = 1'b0; if_pc = 32'h44; #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL bb_ctr1 got=%b exp=0", pred_taken); end
    if_pc = 32'h48; #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL bb_ctr2 got=%b exp=0", pred_taken); end
    n_cmp++; if (mispred_cnt !== 2'd1) begin n_err++; $display("FAIL bb_cnt got=%0d exp=1", mispred_cnt); end
  endtask

  task automatic test_stall();
    apply_reset();
    fetch_to_ex(32'h40);
    pipe_en = 1'b0; is_br_ex = 1'b1; branch_ex = 1'b1; ex_target = 32'h100; if_pc = 32'h40; #1;
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL st_flush0 got=%b exp=1", flush); end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL st_flush got=%b exp=1", flush); end
      n_cmp++; if (redirect_pc !== 32'h100) begin n_err++; $display("FAIL st_redirect got=%h exp=100", redirect_pc); end
      n_cmp++; if (mispred_cnt !== 2'd0) begin n_err++; $display("FAIL st_cnt got=%0d exp=0", mispred_cnt); end
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL st_ctr got=%b exp=0", pred_taken); end
    end
    pipe_en = 1'b1;
    tick();
    is_br_ex = 1'b0; branch_ex = 1'b0; #1;
    n_cmp++; if (mispred_cnt !== 2'd1) begin n_err++; $display("FAIL st_cnt_after got=%0d exp=1", mispred_cnt); end
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL st_ctr_after got=%b exp=1", pred_taken); end
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL st_flush_after got=%b exp=0", flush); end
  endtask

  task automatic test_cnt_sat_and_reset();
    logic [4:0] pat;
    apply_reset();
    pat = 5'b10101;
    // Alternating outcomes on one entry mispredict every time from 01.
    for (int i = 0; i < 5; i++) begin
      run_branch(32'h40, pat[i]);
      if (i == 2) begin
        n_cmp++; if (mispred_cnt !== 2'd3) begin n_err++; $display("FAIL sat_cnt3 got=%0d exp=3", mispred_cnt); end
      end
    end
    n_cmp++; if (mispred_cnt !== 2'd3) begin n_err++; $display("FAIL sat_cnt5 got=%0d exp=3", mispred_cnt); end
    if_pc = 32'h40; #1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL sat_ctr0 got=%b exp=1", pred_taken); end
    fetch_to_ex(32'h44);
    is_br_ex = 1'b1; branch_ex = 1'b1; ex_target = 32'h200; if_pc = 32'h40; #1;
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL mr_flush got=%b exp=1", flush); end
    #2 rst_n = 1'b0; #1;
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL mr_flush_async got=%b exp=0", flush); end
    n_cmp++; if (mispred_cnt !== 2'd0) begin n_err++; $display("FAIL mr_cnt got=%0d exp=0", mispred_cnt); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL mr_ctr got=%b exp=0", pred_taken); end
    tick();
    rst_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    test_reset();
    test_mispredict_taken();
    test_train_saturate();
    test_back_to_back_squash();
    test_stall();
    test_cnt_sat_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=done");
    $fatal(1, "timeout");
  end
endmodule
